// File: rtl/seg_display_driver.sv
// Multi-digit seven-segment driver.
// Takes a value over a valid/ready handshake and renders it as decimal (serial
// double-dabble) or hex on NUM_DIGITS active-low displays. It supports
// leading-zero blanking, overflow dashes and a blank override.
module seg_display_driver #(
   parameter int NUM_DIGITS = 8,
   parameter int VALUE_W    = 16,
   parameter bit BLANK_LEAD = 1'b1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [VALUE_W-1:0]          in_value,
   input  logic                        hex_mode,
   input  logic                        blank_en,
   output logic                        busy,
   output logic [NUM_DIGITS-1:0][6:0]  digit
);

   localparam int NUM_NIBS = (VALUE_W + 3) / 4;
   localparam int PAD_N    = (NUM_NIBS > NUM_DIGITS) ? NUM_NIBS : NUM_DIGITS;
   localparam int BCD_W    = 4 * NUM_DIGITS;
   localparam int CNT_W    = (VALUE_W > 1) ? $clog2(VALUE_W) : 1;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   typedef enum logic [1:0] {S_IDLE, S_CONV, S_LOAD} state_t;

   state_t                        state_q, state_d;
   logic [VALUE_W-1:0]            shreg_q, shreg_d;
   logic                          hex_q, hex_d;
   logic [BCD_W-1:0]              bcd_q, bcd_d;
   logic                          ovf_q, ovf_d;
   logic [CNT_W-1:0]              cnt_q, cnt_d;
   logic [NUM_DIGITS-1:0][6:0]    img_q, img_d;
   logic [NUM_DIGITS-1:0][6:0]    digit_q, digit_d;

   logic [BCD_W-1:0]              bcd_adj;
   logic                          ovf_bit;
   logic [NUM_DIGITS-1:0][6:0]    image;
   logic [4*PAD_N-1:0]            pad;
   logic                          hex_ovf;
   logic                          seen_nz;
   logic                          present;
   logic [3:0]                    nib;

   // Nibble to gfedcba segment pattern, active low.
   function automatic logic [6:0] seg_code(input logic [3:0] n);
      case (n)
         4'h0:    seg_code = 7'b1000000;
         4'h1:    seg_code = 7'b1111001;
         4'h2:    seg_code = 7'b0100100;
         4'h3:    seg_code = 7'b0110000;
         4'h4:    seg_code = 7'b0011001;
         4'h5:    seg_code = 7'b0010010;
         4'h6:    seg_code = 7'b0000010;
         4'h7:    seg_code = 7'b1111000;
         4'h8:    seg_code = 7'b0000000;
         4'h9:    seg_code = 7'b0011000;
         4'hA:    seg_code = 7'b0001000;
         4'hB:    seg_code = 7'b0000011;
         4'hC:    seg_code = 7'b1000110;
         4'hD:    seg_code = 7'b0100001;
         4'hE:    seg_code = 7'b0000110;
         default: seg_code = 7'b0001110;
      endcase
   endfunction

   assign in_ready = (state_q == S_IDLE);
   assign busy     = (state_q != S_IDLE);
   assign digit    = digit_q;

   // Next-state logic: handshake, double-dabble step, and image capture in LOAD.
   always_comb begin
      // NOTE: every variable gets a default before the case so that no path
      // leaves a value unassigned, which would infer a latch.
      state_d = state_q;
      shreg_d = shreg_q;
      hex_d   = hex_q;
      bcd_d   = bcd_q;
      ovf_d   = ovf_q;
      cnt_d   = cnt_q;
      img_d   = img_q;
      bcd_adj = '0;
      ovf_bit = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               shreg_d = in_value;
               hex_d   = hex_mode;
               bcd_d   = '0;
               ovf_d   = 1'b0;
               cnt_d   = '0;
               state_d = hex_mode ? S_LOAD : S_CONV;
            end
         end
         S_CONV: begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
               bcd_adj[i*4 +: 4] = (bcd_q[i*4 +: 4] >= 4'd5) ? bcd_q[i*4 +: 4] + 4'd3
                                                             : bcd_q[i*4 +: 4];
            end
            {ovf_bit, bcd_d, shreg_d} = {bcd_adj, shreg_q, 1'b0};
            ovf_d = ovf_q | ovf_bit;
            if (cnt_q == CNT_W'(VALUE_W - 1)) begin
               state_d = S_LOAD;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_LOAD: begin
            img_d   = image;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Display image from the converted digits or hex nibbles.
   // Applies leading-zero blanking and replaces the image with dashes on overflow.
   always_comb begin
      pad     = '0;
      pad[VALUE_W-1:0] = shreg_q;
      hex_ovf = 1'b0;
      seen_nz = 1'b0;
      present = 1'b0;
      nib     = 4'h0;
      image   = {NUM_DIGITS{SEG_BLANK}};
      for (int j = NUM_DIGITS; j < PAD_N; j++) begin
         if (pad[j*4 +: 4] != 4'h0) hex_ovf = 1'b1;
      end
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         present = hex_q ? (i < NUM_NIBS) : 1'b1;
         nib     = hex_q ? pad[i*4 +: 4] : bcd_q[i*4 +: 4];
         if (present && nib != 4'h0) seen_nz = 1'b1;
         if (!present || (BLANK_LEAD && !seen_nz && i != 0)) begin
            image[i] = SEG_BLANK;
         end else begin
            image[i] = seg_code(nib);
         end
      end
      if (hex_q ? hex_ovf : ovf_q) begin
         image = {NUM_DIGITS{SEG_DASH}};
      end
   end

   // Output stage: the blank override is applied on the registered path.
   always_comb begin
      digit_d = blank_en ? {NUM_DIGITS{SEG_BLANK}} : img_q;
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // flop samples the pre-edge value of every other flop.
      if (rst) begin
         state_q <= S_IDLE;
         shreg_q <= '0;
         hex_q   <= 1'b0;
         bcd_q   <= '0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
         img_q   <= {NUM_DIGITS{SEG_BLANK}};
         digit_q <= {NUM_DIGITS{SEG_BLANK}};
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         hex_q   <= hex_d;
         bcd_q   <= bcd_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
         img_q   <= img_d;
         digit_q <= digit_d;
      end
   end

endmodule
